// File: rtl/fpg8_mem_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester port indices and the round-robin helper.
package fpg8_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    // Port that should win a tie, given which port won the previous grant.
    function automatic logic other_port(input logic last_port);
        if (last_port == PORT0) begin
            return PORT1;
        end else begin
            return PORT0;
        end
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin grant selection.
module rr_pick2
    import fpg8_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Single requesters always win; a tie goes to the port not granted last.
    always_comb begin
        grant_valid = |req;
        case (req)
            2'b01:   grant_idx = PORT0;
            2'b10:   grant_idx = PORT1;
            2'b11:   grant_idx = other_port(last_grant);
            default: grant_idx = PORT0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter: IDLE -> ACCESS -> DONE, one access
// per three cycles, round-robin between p0 and p1, all outputs registered.
module mem_arbiter
    import fpg8_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  ram_w_en,
    output logic                  ram_r_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic [DATA_WIDTH-1:0] ram_data,
    output logic                  busy
);

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    last_grant_r;
    logic                    gnt_idx_r;
    logic                    grant_valid_s;
    logic                    grant_idx_s;
    logic                    load_s;
    logic                    finish_s;
    logic                    sel_we_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;

    rr_pick2 u_pick (
        .req         ({p1_req, p0_req}),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: a grant always runs the full three-cycle sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: next_state_s = ST_DONE;
            ST_DONE:   next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Output decode: when to latch a request and when to complete it.
    always_comb begin
        load_s   = 1'b0;
        finish_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_ACCESS: finish_s = 1'b1;
            ST_DONE:   finish_s = 1'b0;
            default:   finish_s = 1'b0;
        endcase
    end

    // Request fields of the port about to be granted.
    always_comb begin
        if (grant_idx_s == PORT1) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Registered RAM interface, acks and read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r   <= PORT1;
            gnt_idx_r      <= PORT0;
            ram_w_en       <= 1'b0;
            ram_r_en       <= 1'b0;
            ram_addr       <= {ADDR_WIDTH{1'b0}};
            ram_write_data <= {DATA_WIDTH{1'b0}};
            p0_ack         <= 1'b0;
            p1_ack         <= 1'b0;
            p0_rdata       <= {DATA_WIDTH{1'b0}};
            p1_rdata       <= {DATA_WIDTH{1'b0}};
            busy           <= 1'b0;
        end else begin
            busy   <= (next_state_s != ST_IDLE);
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            if (load_s) begin
                gnt_idx_r      <= grant_idx_s;
                last_grant_r   <= grant_idx_s;
                ram_w_en       <= sel_we_s;
                ram_r_en       <= ~sel_we_s;
                ram_addr       <= sel_addr_s;
                ram_write_data <= sel_wdata_s;
            end else if (finish_s) begin
                ram_w_en <= 1'b0;
                ram_r_en <= 1'b0;
                if (gnt_idx_r == PORT1) begin
                    p1_ack <= 1'b1;
                    if (ram_r_en) begin
                        p1_rdata <= ram_data;
                    end
                end else begin
                    p0_ack <= 1'b1;
                    if (ram_r_en) begin
                        p0_rdata <= ram_data;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-timeline reference model
// and a behavioural RAM.
module tb_mem_arbiter;

    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p0_addr = '0, p1_addr = '0;
    logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
    logic          p0_ack, p1_ack, ram_w_en, ram_r_en, busy;
    logic [DW-1:0] p0_rdata, p1_rdata, ram_write_data, ram_data;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    // Reference model: the one grant in flight and what it implies over time.
    bit            g_valid;
    int            g_edge;
    bit            g_port, g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    bit            m_last;
    logic [DW-1:0] m_rdata [2];
    int            ack_order [$];

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_w_en(ram_w_en), .ram_r_en(ram_r_en), .ram_addr(ram_addr),
        .ram_write_data(ram_write_data), .ram_data(ram_data), .busy(busy)
    );

    always #5 clk = ~clk;

    assign ram_data = ram_r_en ? ram[ram_addr] : 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, edge_cnt);
        end
    endtask

    task automatic model_reset();
        g_valid    = 1'b0;
        m_last     = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
    endtask

    // Decide, from the inputs now applied, whether edge e starts an access.
    task automatic model_decide(input int e);
        bit idle;
        idle = !g_valid || (e >= g_edge + 3);
        if (!rst && idle && (p0_req || p1_req)) begin
            if (p0_req && p1_req) g_port = !m_last;
            else                  g_port = p1_req;
            m_last  = g_port;
            g_valid = 1'b1;
            g_edge  = e;
            g_we    = g_port ? p1_we    : p0_we;
            g_addr  = g_port ? p1_addr  : p0_addr;
            g_wdata = g_port ? p1_wdata : p0_wdata;
        end
    endtask

    // Compare DUT outputs after edge e against what the model predicts.
    task automatic check_cycle(input int e);
        bit acc, fin;
        acc = g_valid && (e == g_edge);
        fin = g_valid && (e == g_edge + 1);
        if (fin) begin
            if (g_we) ref_mem[g_addr] = g_wdata;
            else      m_rdata[g_port] = ref_mem[g_addr];
        end
        chk("ram_w_en", 32'(ram_w_en), 32'(acc && g_we));
        chk("ram_r_en", 32'(ram_r_en), 32'(acc && !g_we));
        if (acc) begin
            chk("ram_addr", 32'(ram_addr), 32'(g_addr));
            if (g_we) chk("ram_write_data", 32'(ram_write_data), 32'(g_wdata));
        end
        chk("p0_ack", 32'(p0_ack), 32'(fin && !g_port));
        chk("p1_ack", 32'(p1_ack), 32'(fin && g_port));
        chk("p0_rdata", 32'(p0_rdata), 32'(m_rdata[0]));
        chk("p1_rdata", 32'(p1_rdata), 32'(m_rdata[1]));
        chk("busy", 32'(busy), 32'(acc || fin));
        chk("en_excl", 32'(ram_w_en & ram_r_en), 32'd0);
        chk("ack_excl", 32'(p0_ack & p1_ack), 32'd0);
    endtask

    task automatic tick();
        if (ram_w_en) ram[ram_addr] = ram_write_data;
        model_decide(edge_cnt + 1);
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        check_cycle(edge_cnt);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 8'hFF;
            1:       return 8'($urandom);
            default: return 8'hF8 + 8'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic randomize_inputs();
        p0_req   = ($urandom_range(0, 9) < 6);
        p0_we    = 1'($urandom_range(0, 1));
        p0_addr  = pick_addr();
        p0_wdata = 16'($urandom);
        p1_req   = ($urandom_range(0, 9) < 6);
        p1_we    = 1'($urandom_range(0, 1));
        p1_addr  = pick_addr();
        p1_wdata = 16'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 16'(i * 257) ^ 16'h5A5A;
            ref_mem[i] = ram[i];
        end
        model_reset();
        repeat (2) @(negedge clk);

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acks", 32'({p0_ack, p1_ack}), 32'd0);
        chk("rst_en", 32'({ram_w_en, ram_r_en}), 32'd0);
        chk("rst_addr", 32'(ram_addr), 32'd0);
        chk("rst_wdata", 32'(ram_write_data), 32'd0);
        chk("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'd0);

        // p0 write 16'hBEEF to 8'h10, granted at the very first edge after reset.
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 8'h10; p0_wdata = 16'hBEEF;
        rst = 1'b0;
        tick();
        chk("wr_w_en", 32'(ram_w_en), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'h10);
        tick();
        chk("wr_ack", 32'(p0_ack), 32'd1);
        p0_req = 1'b0;
        tick();

        // p1 reads the value back; p0_rdata must not move.
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 8'h10;
        tick();
        tick();
        chk("rd_p1_rdata", 32'(p1_rdata), 32'hBEEF);
        chk("rd_p0_hold", 32'(p0_rdata), 32'd0);
        p1_req = 1'b0;
        tick();

        // Both request continuously: strict alternation starting with p0.
        p0_req = 1'b1; p1_req = 1'b1; p0_we = 1'b0; p1_we = 1'b0;
        ack_order.delete();
        for (int i = 0; i < 12; i++) begin
            tick();
            if (p0_ack) ack_order.push_back(0);
            if (p1_ack) ack_order.push_back(1);
        end
        chk("rr_count", 32'(ack_order.size()), 32'd4);
        for (int i = 0; i < ack_order.size(); i++) chk("rr_order", 32'(ack_order[i]), 32'(i % 2));
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) tick();

        // p0 drops req right after the grant; the access still completes.
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 8'hFF;
        tick();
        p0_req = 1'b0;
        tick();
        chk("drop_ack", 32'(p0_ack), 32'd1);
        tick();

        for (int i = 0; i < 1500; i++) begin
            randomize_inputs();
            tick();
        end
        p0_req = 1'b0; p1_req = 1'b0;
        repeat (3) tick();

        // Reset in the ACCESS cycle of a write to 8'hFD.
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'hFD; p1_wdata = 16'h1234;
        tick();
        chk("abort_pre_w_en", 32'(ram_w_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_w_en", 32'(ram_w_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_acks", 32'({p0_ack, p1_ack}), 32'd0);
        model_reset();
        p1_req = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            randomize_inputs();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of RAM words and requester data buses.
REQ-002 Parameter ADDR_WIDTH, default 8: RAM address width (256-word RAM).
REQ-003 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-high reset.
REQ-005 Ports p0_req / p1_req  input  1 each: requester N wants one RAM access.
REQ-006 Ports p0_we / p1_we  input  1 each: 1 = write, 0 = read; sampled at grant.
REQ-007 Ports p0_addr / p1_addr  input  ADDR_WIDTH each: access address; sampled at grant.
REQ-008 Ports p0_wdata / p1_wdata  input  DATA_WIDTH each: write data; sampled at grant.
REQ-009 Ports p0_ack / p1_ack  output  1 each: one-cycle completion pulse for requester N.
REQ-010 Ports p0_rdata / p1_rdata  output  DATA_WIDTH each: registered read result for requester N.
REQ-011 Port ram_w_en  output  1: RAM write enable.
REQ-012 Port ram_r_en  output  1: RAM read enable, which drives the RAM tri-state data bus.
REQ-013 Port ram_addr  output  ADDR_WIDTH: RAM address.
REQ-014 Port ram_write_data  output  DATA_WIDTH: RAM write data.
REQ-015 Port ram_data  input  DATA_WIDTH: RAM read bus; valid only while ram_r_en = 1.
REQ-016 Port busy  output  1: high whenever the FSM is not in IDLE.

Function
REQ-017 FSM states: IDLE, ACCESS and DONE; all RAM-side outputs are registered.
REQ-018 In IDLE with any req high, the FSM grants one port and latches that port's we, addr and wdata, then moves to ACCESS on the next edge.
REQ-019 In ACCESS, for exactly one cycle: ram_addr = latched addr, and ram_w_en = we or ram_r_en = !we; ram_w_en and ram_r_en are never both 1.
REQ-020 At the end of an ACCESS read, ram_data is captured into the granted port's rdata only.
REQ-021 The FSM then moves to DONE and pulses the granted port's ack for one cycle.
REQ-022 From DONE the FSM returns to IDLE; the next grant is possible in the following cycle.
REQ-023 Latency: req high in cycle N (IDLE) gives RAM access in N+1, ack and rdata valid in N+2; throughput is one access per 3 cycles.
REQ-024 Arbitration is round-robin: a 1-bit last_grant pointer selects the other port when both request; after reset it prefers p0.
REQ-025 A single requester is granted regardless of the last_grant value.
REQ-026 The non-granted port's rdata holds its previous value and its ack stays 0.
REQ-027 A requester holds req until ack; dropping req after grant does not cancel the access, and ack is still issued.
REQ-028 A req still high in the cycle after ack is treated as a new request.
REQ-029 Address wrap: no bounds logic; addr 8'hFF is a legal access.
REQ-030 ram_write_data equals the latched wdata during ACCESS and holds its value at other times (don't-care to the RAM).

Reset
REQ-031 While rst = 1: state = IDLE, last_grant = 1 (so p0 is preferred), all acks = 0, ram_w_en = 0, ram_r_en = 0, ram_addr = 0, ram_write_data = 0, p0_rdata = p1_rdata = 0, busy = 0.
REQ-032 Reset asserted mid-ACCESS drops ram_w_en and ram_r_en immediately (asynchronously), no ack is issued, and the aborted write is not guaranteed to land.
REQ-033 After reset deassertion, the first grant is possible at the first rising clk edge.

Structure
REQ-034 The state encoding (IDLE, ACCESS, DONE) and the port index constants (PORT0, PORT1) live in a shared package, fpg8_mem_pkg.
REQ-035 The grant choice is one combinational sub-module, rr_pick2: inputs req[1:0] and last_grant; outputs grant_valid and grant_idx.

Verification
REQ-036 Reset, then p0 writes 16'hBEEF to addr 8'h10 -> in the ACCESS cycle ram_w_en = 1 and ram_addr = 8'h10; p0_ack pulses 2 cycles after req.
REQ-037 p1 reads addr 8'h10 with RAM model returning 16'hBEEF -> p1_rdata = 16'hBEEF at p1_ack; p0_rdata is unchanged.
REQ-038 Both ports request continuously after reset -> grant order is p0, p1, p0, p1, with acks every 3 cycles.
REQ-039 p0 drops req in the cycle after grant -> the access still completes and p0_ack pulses once.
REQ-040 rst asserted during ACCESS of a write to 8'hFD -> ram_w_en = 0 in the same cycle, no ack, busy = 0.
REQ-041 Every cycle of every test: ram_w_en and ram_r_en are never both 1, and at most one ack is high.
